serial_word_rx: RTL
===================

# serial_word_rx

Downstream companion of the team's N-bit shift register. Consumes its MSB-first serial output one bit per qualified cycle, regroups the bits into N-bit words (with an optional trailing even-parity bit), and presents completed words on a valid/ready interface through a 2-entry output FIFO. Sits between the shift-register stage and any word-oriented consumer.

## Interface
Parameters:
- N, 4, data bits per frame (N ≥ 2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- bit_in  input  1  serial data bit, MSB of the word first
- bit_valid  input  1  bit_in is sampled on this edge
- frame_clear  input  1  synchronous; discards any partial frame
- word_out  output  N  head-of-FIFO word
- word_valid  output  1  FIFO not empty
- word_ready  input  1  consumer accepts word_out this cycle
- overflow  output  1  sticky; a completed frame was dropped because the FIFO was full
- ovf_clear  input  1  synchronous clear of overflow
- parity_err  output  1  one-cycle pulse; frame dropped on parity mismatch

## Operation
- Assembly register asm_q (N bits) and bit counter cnt (0..F-1), where F = N+1 with parity enabled and F = N without it.
- On bit_valid: asm_q <= {asm_q[N-2:0], bit_in} while cnt < N; cnt increments; the final bit of the frame (cnt == F-1) completes the frame and cnt wraps to 0.
- With parity enabled, bit N is the parity bit: the frame is good when XOR(data bits, parity bit) == 0 (even parity).
- Frame completion: a good frame is pushed into the FIFO. If the FIFO is full and there is no pop in the same cycle, the frame is dropped and overflow is set.
- Pop: when word_valid && word_ready, the head entry is removed.
- Simultaneous push and pop with the FIFO full: both take effect and overflow is not set. With the FIFO empty: the push lands, and the pop is ignored because word_valid was 0.
- frame_clear has priority over bit_valid: cnt <= 0 and asm_q <= 0. It does not affect the FIFO, overflow, or a bit presented in the same cycle, which is discarded.
- ovf_clear clears overflow unless an overflow event occurs in the same cycle; the event wins.
- FIFO: 2 entries, pointers wrap modulo 2, occupancy 0..2. word_valid = (occupancy != 0).

## Timing
- Reset values: word_out = 0, word_valid = 0, overflow = 0, parity_err = 0, cnt = 0, asm_q = 0, FIFO empty.
- Asserting rstn mid-frame or with the FIFO occupied discards everything immediately (asynchronous).
- Latency: the word is visible on word_out/word_valid in the cycle after the edge that samples the last frame bit.
- parity_err is registered: high for exactly one cycle following the edge that completed a bad frame.
- overflow rises in the cycle after the dropping edge.
- bit_valid may be held high continuously. Full throughput is one frame per F cycles. With word_ready held high, no overflow occurs.
- word_out is stable while word_valid = 1 and word_ready = 0.

## Configuration
- PARITY_CHECK_EN defined: F = N+1. The trailing even-parity bit is checked, and bad frames are dropped with a parity_err pulse.
- PARITY_CHECK_EN undefined: F = N and there is no parity bit. parity_err is tied to 0. Every completed frame goes to the FIFO.

## Test plan
- Reset, no parity, N=4, ready=1: bits 1,0,1,1 with bit_valid=1 -> word_out=4'hB, word_valid=1 for one cycle in the cycle after the 4th bit edge.
- PARITY_CHECK_EN, N=4: bits 1,0,1,1 then parity 1 -> 4'hB delivered, parity_err=0. The same frame with parity 0 -> no word, parity_err pulses for 1 cycle.
- ready=0, three back-to-back frames 4'h1, 4'h2, 4'h3 -> FIFO holds 1, 2. The third is dropped and overflow=1. Then ready=1 -> 4'h1, 4'h2 popped in order. overflow stays 1 until ovf_clear.
- FIFO full, ready=1 on the same edge a 4'h5 frame completes -> pop and push both occur, overflow=0, and 4'h5 is the last word out.
- frame_clear after two bits (1,1), then bits 0,1,1,0 -> word_out=4'h6, with no trace of the discarded bits.
- rstn asserted with 1 word in the FIFO and 2 bits assembled -> all outputs 0 immediately. After release, a fresh 4-bit frame 4'hA is received correctly.

Source files
------------

// File: rtl/serial_word_rx.sv
// Serial-to-word receiver: regroups MSB-first bits into N-bit words behind a 2-entry valid/ready FIFO.
// Define PARITY_CHECK_EN to append and check a trailing even-parity bit per frame.
module serial_word_rx #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         frame_clear,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         overflow,
    input  logic         ovf_clear,
    output logic         parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int unsigned F  = N + 1;
    localparam int unsigned AW = N;
`else
    localparam int unsigned F  = N;
    // the last data bit goes straight to the FIFO, so only N-1 bits need holding
    localparam int unsigned AW = N - 1;
`endif
    localparam int unsigned CW = $clog2(F + 1);

    logic [AW-1:0] asm_q, asm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mem_q [2];
    logic [N-1:0]  mem_d [2];
    logic          wr_q, wr_d, rd_q, rd_d;
    logic [1:0]    occ_q, occ_d;
    logic          overflow_d, parity_err_d, word_valid_d;
    logic [N-1:0]  word_out_d;
    logic          frame_done, frame_good, push, pop, drop;
    logic [N-1:0]  frame_word;

    // Frame assembly and bit counting
    always_comb begin
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        frame_done = 1'b0;
        if (frame_clear) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (bit_valid) begin
            if (cnt_q < CW'(N)) begin
                asm_d = AW'({asm_q, bit_in});
            end
            if (cnt_q == CW'(F - 1)) begin
                cnt_d      = '0;
                frame_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

`ifdef PARITY_CHECK_EN
    assign frame_word = asm_q;
    assign frame_good = ~(^{asm_q, bit_in});
`else
    assign frame_word = {asm_q, bit_in};
    assign frame_good = 1'b1;
`endif

    // FIFO bookkeeping and registered output next-state
    always_comb begin
        mem_d        = mem_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        pop          = word_valid && word_ready;
        push         = frame_done && frame_good && ((occ_q != 2'd2) || pop);
        drop         = frame_done && frame_good && !push;
        if (push) begin
            mem_d[wr_q] = frame_word;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        occ_d        = occ_q + 2'(push) - 2'(pop);
        overflow_d   = drop ? 1'b1 : (ovf_clear ? 1'b0 : overflow);
        parity_err_d = frame_done && !frame_good;
        word_valid_d = (occ_d != 2'd0);
        word_out_d   = mem_d[rd_d];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_q      <= '0;
            cnt_q      <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            occ_q      <= 2'd0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            word_valid <= 1'b0;
            word_out   <= '0;
        end else begin
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            occ_q      <= occ_d;
            overflow   <= overflow_d;
            parity_err <= parity_err_d;
            word_valid <= word_valid_d;
            word_out   <= word_out_d;
        end
    end

endmodule
